// File: rtl/multicycle_ctrl_pkg.sv
// ============================================================================
// multicycle_ctrl_pkg : opcodes, state encoding and datapath select codes
// Revision 1.0
// ============================================================================
`default_nettype none

package multicycle_ctrl_pkg;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_FETCH   = 4'd1,
        S_DECODE  = 4'd2,
        S_EXEC    = 4'd3,
        S_ALUWB   = 4'd4,
        S_MEMADDR = 4'd5,
        S_MEMRD   = 4'd6,
        S_MEMWB   = 4'd7,
        S_MEMWR   = 4'd8,
        S_BRANCH  = 4'd9,
        S_JAL     = 4'd10,
        S_TRAP    = 4'd11
    } state_t;

    localparam logic [1:0] ALUOP_ADD  = 2'b00;
    localparam logic [1:0] ALUOP_SUB  = 2'b01;
    localparam logic [1:0] ALUOP_FUNC = 2'b10;
    localparam logic [1:0] ALUOP_IFUN = 2'b11;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_FOUR = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

`default_nettype wire

// File: rtl/multicycle_ctrl_if.sv
// ============================================================================
// multicycle_ctrl_if : controller <-> datapath/memory signal bundle
// Revision 1.0
// ============================================================================
`default_nettype none

interface multicycle_ctrl_if #(
    parameter int CNT_W = 32
);
    logic [6:0]       Opcode;
    logic             Zero;
    logic             MemReady;
    logic             PCWrite;
    logic             PCWriteCond;
    logic             IorD;
    logic             MemRead;
    logic             MemWrite;
    logic             IRWrite;
    logic             MemtoReg;
    logic             RegWrite;
    logic             ALUSrcA;
    logic [1:0]       ALUSrcB;
    logic [1:0]       ALUOp;
    logic [1:0]       PCSource;
    logic             IllegalInst;
    logic             MemTimeout;
    logic [CNT_W-1:0] RetireCnt;

    modport master (
        input  Opcode, Zero, MemReady,
        output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
               MemtoReg, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource,
               IllegalInst, MemTimeout, RetireCnt
    );

    modport slave (
        output Opcode, Zero, MemReady,
        input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
               MemtoReg, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource,
               IllegalInst, MemTimeout, RetireCnt
    );
endinterface

`default_nettype wire

// File: rtl/multicycle_ctrl_mem_wait_timer.sv
// ============================================================================
// mem_wait_timer : 8-bit wait counter; o_last flags the final allowed cycle
// Revision 1.0
// ============================================================================
`default_nettype none

module mem_wait_timer #(
    parameter int MEM_TIMEOUT = 15
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic i_clr,
    input  wire logic i_en,
    output logic      o_last
);
    localparam logic [7:0] c_LAST = 8'(MEM_TIMEOUT - 1);

    logic [7:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_cnt <= 8'd0;
        end else if (i_en && (r_cnt != 8'hFF)) begin
            r_cnt <= r_cnt + 8'd1;
        end
    end

    // High during the MEM_TIMEOUT-th waiting cycle; a ready in that cycle still wins
    assign o_last = (r_cnt == c_LAST);

endmodule

`default_nettype wire

// File: rtl/multicycle_ctrl.sv
// ============================================================================
// multicycle_ctrl : multi-cycle RV32 control FSM with memory handshake,
//                   illegal-opcode/timeout trap and retired-instruction count
// Revision 1.0
// ============================================================================
`default_nettype none

module multicycle_ctrl #(
    parameter bit EN_IALU     = 1'b1,
    parameter bit EN_JAL      = 1'b1,
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 32
) (
    input  wire logic          Clk,
    input  wire logic          Rst,
    multicycle_ctrl_if.master  bus
);
    import multicycle_ctrl_pkg::*;

    state_t           r_state, w_next;
    logic             r_is_sw, r_illegal, r_timeout;
    logic [CNT_W-1:0] r_retire;
    logic             w_mem_state, w_tmr_last, w_wait_trap, w_illegal_dec, w_retire;

    assign w_mem_state = (r_state == S_FETCH) || (r_state == S_MEMRD) || (r_state == S_MEMWR);
    assign w_wait_trap = w_mem_state && !bus.MemReady && w_tmr_last;
    assign w_retire    = (w_next == S_FETCH) &&
                         (r_state inside {S_ALUWB, S_MEMWB, S_MEMWR, S_BRANCH, S_JAL});

    mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
        .clk    (Clk),
        .rst    (Rst),
        .i_clr  (w_next != r_state),
        .i_en   (w_mem_state && !bus.MemReady),
        .o_last (w_tmr_last)
    );

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_state   <= S_IDLE;
            r_is_sw   <= 1'b0;
            r_illegal <= 1'b0;
            r_timeout <= 1'b0;
            r_retire  <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_DECODE) r_is_sw <= (bus.Opcode == OP_SW);
            if (w_illegal_dec)       r_illegal <= 1'b1;
            if (w_wait_trap)         r_timeout <= 1'b1;
            if (w_retire)            r_retire  <= r_retire + CNT_W'(1);
        end
    end

    always_comb begin
        w_next        = r_state;
        w_illegal_dec = 1'b0;
        case (r_state)
            S_IDLE:   w_next = S_FETCH;
            S_FETCH:  if (bus.MemReady) w_next = S_DECODE; else if (w_tmr_last) w_next = S_TRAP;
            S_DECODE: begin
                case (bus.Opcode)
                    OP_R:         w_next = S_EXEC;
                    OP_I:         if (EN_IALU) w_next = S_EXEC; else w_illegal_dec = 1'b1;
                    OP_LW, OP_SW: w_next = S_MEMADDR;
                    OP_BEQ:       w_next = S_BRANCH;
                    OP_JAL:       if (EN_JAL) w_next = S_JAL; else w_illegal_dec = 1'b1;
                    default:      w_illegal_dec = 1'b1;
                endcase
                if (w_illegal_dec) w_next = S_TRAP;
            end
            S_EXEC:    w_next = S_ALUWB;
            S_ALUWB:   w_next = S_FETCH;
            S_MEMADDR: w_next = r_is_sw ? S_MEMWR : S_MEMRD;
            S_MEMRD:   if (bus.MemReady) w_next = S_MEMWB; else if (w_tmr_last) w_next = S_TRAP;
            S_MEMWB:   w_next = S_FETCH;
            S_MEMWR:   if (bus.MemReady) w_next = S_FETCH; else if (w_tmr_last) w_next = S_TRAP;
            S_BRANCH:  w_next = S_FETCH;
            S_JAL:     w_next = S_FETCH;
            S_TRAP:    w_next = S_TRAP;
            default:   w_next = S_IDLE;
        endcase
    end

    // Moore decode; IRWrite/PCWrite in FETCH follow MemReady directly
    always_comb begin
        bus.PCWrite     = 1'b0;
        bus.PCWriteCond = 1'b0;
        bus.IorD        = 1'b0;
        bus.MemRead     = 1'b0;
        bus.MemWrite    = 1'b0;
        bus.IRWrite     = 1'b0;
        bus.MemtoReg    = 1'b0;
        bus.RegWrite    = 1'b0;
        bus.ALUSrcA     = 1'b0;
        bus.ALUSrcB     = SRCB_RS2;
        bus.ALUOp       = ALUOP_ADD;
        bus.PCSource    = PCSRC_ALU;
        case (r_state)
            S_FETCH: begin
                bus.MemRead = 1'b1;
                bus.ALUSrcB = SRCB_FOUR;
                bus.IRWrite = bus.MemReady;
                bus.PCWrite = bus.MemReady;
            end
            S_DECODE:  bus.ALUSrcB = SRCB_IMM;
            S_EXEC: begin
                bus.ALUSrcA = 1'b1;
                bus.ALUSrcB = r_is_itype_c() ? SRCB_IMM : SRCB_RS2;
                bus.ALUOp   = r_is_itype_c() ? ALUOP_IFUN : ALUOP_FUNC;
            end
            S_ALUWB:   bus.RegWrite = 1'b1;
            S_MEMADDR: begin
                bus.ALUSrcA = 1'b1;
                bus.ALUSrcB = SRCB_IMM;
            end
            S_MEMRD: begin
                bus.MemRead = 1'b1;
                bus.IorD    = 1'b1;
            end
            S_MEMWB: begin
                bus.RegWrite = 1'b1;
                bus.MemtoReg = 1'b1;
            end
            S_MEMWR: begin
                bus.MemWrite = 1'b1;
                bus.IorD     = 1'b1;
            end
            S_BRANCH: begin
                bus.ALUSrcA     = 1'b1;
                bus.ALUOp       = ALUOP_SUB;
                bus.PCWriteCond = 1'b1;
                bus.PCSource    = PCSRC_ALUOUT;
            end
            S_JAL: begin
                bus.PCWrite  = 1'b1;
                bus.PCSource = PCSRC_JUMP;
                bus.RegWrite = 1'b1;
            end
            default: ;
        endcase
    end

    // I-type flavour of EXEC, remembered from DECODE
    logic r_is_itype;
    always_ff @(posedge Clk) begin
        if (Rst)                       r_is_itype <= 1'b0;
        else if (r_state == S_DECODE)  r_is_itype <= (bus.Opcode == OP_I);
    end

    function automatic logic r_is_itype_c();
        return r_is_itype;
    endfunction

    assign bus.IllegalInst = r_illegal;
    assign bus.MemTimeout  = r_timeout;
    assign bus.RetireCnt   = r_retire;

endmodule

`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
// ============================================================================
// tb_multicycle_ctrl : directed bench for multicycle_ctrl (two configurations)
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_multicycle_ctrl;
    import multicycle_ctrl_pkg::*;

    logic       Clk = 1'b0;
    logic       Rst;
    logic [6:0] opcode;
    logic       memready;
    logic       zero;
    int         checks   = 0;
    int         failures = 0;

    always #5 Clk = ~Clk;

    // a: short timeout, 4-bit counter; b: I-type disabled, default timeout/width
    multicycle_ctrl_if #(.CNT_W(4))  if_a ();
    multicycle_ctrl_if #(.CNT_W(32)) if_b ();

    assign if_a.Opcode = opcode;  assign if_a.MemReady = memready;  assign if_a.Zero = zero;
    assign if_b.Opcode = opcode;  assign if_b.MemReady = memready;  assign if_b.Zero = zero;

    multicycle_ctrl #(.EN_IALU(1'b1), .EN_JAL(1'b1), .MEM_TIMEOUT(4), .CNT_W(4)) dut_a (
        .Clk (Clk), .Rst (Rst), .bus (if_a.master)
    );
    multicycle_ctrl #(.EN_IALU(1'b0), .EN_JAL(1'b1), .MEM_TIMEOUT(15), .CNT_W(32)) dut_b (
        .Clk (Clk), .Rst (Rst), .bus (if_b.master)
    );

    // {PCWrite,PCWriteCond,IorD,MemRead,MemWrite,IRWrite,MemtoReg,RegWrite,ALUSrcA,ALUSrcB,ALUOp,PCSource}
    function automatic logic [14:0] mk(input logic pcw, pcwc, iord, mr, mw, irw, m2r, rw, asa,
                                       input logic [1:0] asb, aop, pcs);
        return {pcw, pcwc, iord, mr, mw, irw, m2r, rw, asa, asb, aop, pcs};
    endfunction

    localparam logic [14:0] E_IDLE   = 15'd0;
    localparam logic [14:0] E_FETCH  = mk(1,0,0,1,0,1,0,0,0, 2'b01, 2'b00, 2'b00);
    localparam logic [14:0] E_FETCHW = mk(0,0,0,1,0,0,0,0,0, 2'b01, 2'b00, 2'b00);
    localparam logic [14:0] E_DECODE = mk(0,0,0,0,0,0,0,0,0, 2'b10, 2'b00, 2'b00);
    localparam logic [14:0] E_EXECR  = mk(0,0,0,0,0,0,0,0,1, 2'b00, 2'b10, 2'b00);
    localparam logic [14:0] E_EXECI  = mk(0,0,0,0,0,0,0,0,1, 2'b10, 2'b11, 2'b00);
    localparam logic [14:0] E_ALUWB  = mk(0,0,0,0,0,0,0,1,0, 2'b00, 2'b00, 2'b00);
    localparam logic [14:0] E_MADDR  = mk(0,0,0,0,0,0,0,0,1, 2'b10, 2'b00, 2'b00);
    localparam logic [14:0] E_MEMRD  = mk(0,0,1,1,0,0,0,0,0, 2'b00, 2'b00, 2'b00);
    localparam logic [14:0] E_MEMWB  = mk(0,0,0,0,0,0,1,1,0, 2'b00, 2'b00, 2'b00);
    localparam logic [14:0] E_MEMWR  = mk(0,0,1,0,1,0,0,0,0, 2'b00, 2'b00, 2'b00);
    localparam logic [14:0] E_BRANCH = mk(0,1,0,0,0,0,0,0,1, 2'b00, 2'b01, 2'b01);
    localparam logic [14:0] E_JAL    = mk(1,0,0,0,0,0,0,1,0, 2'b00, 2'b00, 2'b10);
    localparam logic [14:0] E_TRAP   = 15'd0;

    wire [14:0] sig_a = {if_a.PCWrite, if_a.PCWriteCond, if_a.IorD, if_a.MemRead, if_a.MemWrite,
                         if_a.IRWrite, if_a.MemtoReg, if_a.RegWrite, if_a.ALUSrcA, if_a.ALUSrcB,
                         if_a.ALUOp, if_a.PCSource};
    wire [14:0] sig_b = {if_b.PCWrite, if_b.PCWriteCond, if_b.IorD, if_b.MemRead, if_b.MemWrite,
                         if_b.IRWrite, if_b.MemtoReg, if_b.RegWrite, if_b.ALUSrcA, if_b.ALUSrcB,
                         if_b.ALUOp, if_b.PCSource};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive MemReady for the current cycle, check dut_a's outputs, advance one clock
    task automatic st(input string tag, input logic rdy, input logic [14:0] exp);
        memready = rdy;
        #1;
        chk(tag, 32'(sig_a), 32'(exp));
        @(posedge Clk); #1;
    endtask

    task automatic do_reset();
        Rst = 1'b1;
        repeat (3) @(posedge Clk);
        #1;
        chk("rst_sig_a",   32'(sig_a), 32'(E_IDLE));
        chk("rst_sig_b",   32'(sig_b), 32'(E_IDLE));
        chk("rst_cnt_a",   32'(if_a.RetireCnt), 32'd0);
        chk("rst_flags_a", 32'({if_a.IllegalInst, if_a.MemTimeout}), 32'd0);
        chk("rst_flags_b", 32'({if_b.IllegalInst, if_b.MemTimeout}), 32'd0);
        Rst = 1'b0;
        st("idle", 1'b1, E_IDLE);
    endtask

    task automatic sw_instr();
        opcode = OP_SW;
        st("sw_fetch", 1'b1, E_FETCH);
        st("sw_decode", 1'b1, E_DECODE);
        st("sw_maddr", 1'b1, E_MADDR);
        st("sw_memwr", 1'b1, E_MEMWR);
    endtask

    initial begin
        Rst = 1'b1; memready = 1'b1; opcode = OP_R; zero = 1'b0;
        do_reset();

        // R-type: RegWrite only in ALUWB, one retirement
        st("r_fetch", 1'b1, E_FETCH);
        st("r_decode", 1'b1, E_DECODE);
        st("r_exec", 1'b0, E_EXECR);
        st("r_wb", 1'b0, E_ALUWB);
        chk("r_cnt", 32'(if_a.RetireCnt), 32'd1);

        // lw with three wait cycles; ready lands exactly on the timeout limit
        opcode = OP_LW;
        st("lw_fetch", 1'b1, E_FETCH);
        st("lw_decode", 1'b1, E_DECODE);
        st("lw_maddr", 1'b1, E_MADDR);
        for (int i = 0; i < 3; i++) st("lw_memrd_wait", 1'b0, E_MEMRD);
        st("lw_memrd_rdy", 1'b1, E_MEMRD);
        st("lw_memwb", 1'b0, E_MEMWB);
        chk("lw_cnt", 32'(if_a.RetireCnt), 32'd2);
        chk("lw_no_timeout", 32'(if_a.MemTimeout), 32'd0);

        opcode = OP_BEQ;
        st("beq_fetch", 1'b1, E_FETCH);
        st("beq_decode", 1'b1, E_DECODE);
        st("beq_branch", 1'b1, E_BRANCH);
        chk("beq_cnt", 32'(if_a.RetireCnt), 32'd3);

        // I-type: legal on a, illegal on b
        opcode = OP_I;
        st("i_fetch", 1'b1, E_FETCH);
        st("i_decode", 1'b1, E_DECODE);
        chk("b_illegal", 32'(if_b.IllegalInst), 32'd1);
        chk("b_trap_sig", 32'(sig_b), 32'(E_TRAP));
        st("i_exec", 1'b1, E_EXECI);
        st("i_wb", 1'b1, E_ALUWB);
        chk("i_cnt", 32'(if_a.RetireCnt), 32'd4);
        chk("b_cnt", if_b.RetireCnt, 32'd3);

        opcode = OP_JAL;
        st("jal_fetch", 1'b1, E_FETCH);
        st("jal_decode", 1'b1, E_DECODE);
        st("jal_jal", 1'b1, E_JAL);
        chk("jal_cnt", 32'(if_a.RetireCnt), 32'd5);
        chk("b_sticky", 32'(if_b.IllegalInst), 32'd1);
        chk("b_trap_sig2", 32'(sig_b), 32'(E_TRAP));

        sw_instr();
        chk("sw_cnt", 32'(if_a.RetireCnt), 32'd6);

        // Unsupported opcode traps and stays there
        opcode = 7'h7F;
        st("ill_fetch", 1'b1, E_FETCH);
        st("ill_decode", 1'b1, E_DECODE);
        st("ill_trap0", 1'b1, E_TRAP);
        st("ill_trap1", 1'b1, E_TRAP);
        chk("ill_flag", 32'(if_a.IllegalInst), 32'd1);
        chk("ill_no_to", 32'(if_a.MemTimeout), 32'd0);
        chk("ill_cnt", 32'(if_a.RetireCnt), 32'd6);

        // Fetch timeout after four non-ready cycles
        do_reset();
        for (int i = 0; i < 4; i++) st("to_fetch_wait", 1'b0, E_FETCHW);
        st("to_trap", 1'b1, E_TRAP);
        chk("to_flag", 32'(if_a.MemTimeout), 32'd1);
        chk("to_no_ill", 32'(if_a.IllegalInst), 32'd0);

        // Ready on the fourth fetch cycle wins, then 17 sw wrap the 4-bit counter
        do_reset();
        for (int i = 0; i < 3; i++) st("w_fetch_wait", 1'b0, E_FETCHW);
        opcode = OP_SW;
        st("w_fetch_rdy", 1'b1, E_FETCH);
        st("w_decode", 1'b1, E_DECODE);
        st("w_maddr", 1'b1, E_MADDR);
        st("w_memwr", 1'b1, E_MEMWR);
        chk("w_no_timeout", 32'(if_a.MemTimeout), 32'd0);
        for (int n = 2; n <= 17; n++) begin
            sw_instr();
            if (n >= 15) chk("wrap_cnt", 32'(if_a.RetireCnt), 32'(n % 16));
        end

        // Reset during MEMWR aborts the store
        opcode = OP_SW;
        st("ab_fetch", 1'b1, E_FETCH);
        st("ab_decode", 1'b1, E_DECODE);
        st("ab_maddr", 1'b1, E_MADDR);
        memready = 1'b0;
        Rst = 1'b1;
        #1;
        chk("ab_memwr", 32'(sig_a), 32'(E_MEMWR));
        @(posedge Clk); #1;
        chk("ab_idle_sig", 32'(sig_a), 32'(E_IDLE));
        chk("ab_idle_cnt", 32'(if_a.RetireCnt), 32'd0);
        chk("ab_idle_flags", 32'({if_a.IllegalInst, if_a.MemTimeout}), 32'd0);
        Rst = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
